// File: rtl/hwy_cntry_light_ctrl.sv
// Highway/country intersection lamp controller with dwell timers, all-red clearance and synchronised sensor.
// Latency: sensor to lamp change is 3 edges once the highway minimum green has elapsed; lamps are registered.
// Backpressure: none; the sensor is level-sampled every cycle. Optional MAX_GREEN_EN caps the country green.
module hwy_cntry_light_ctrl #(
    parameter int YEL_CYC       = 3,
    parameter int ALLRED_CYC    = 2,
    parameter int MIN_GRN_CYC   = 4,
    parameter int MAX_CNTRY_CYC = 8,
    parameter int CNT_W         = 4
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       x,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED = 2'd0;
    localparam logic [1:0] LAMP_YEL = 2'd1;
    localparam logic [1:0] LAMP_GRN = 2'd2;

    // Timer values compared against on the last cycle of each dwell.
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GRN_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CNTRY_CYC - 1);

`ifdef MAX_GREEN_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             x_meta_q, x_s_q;
    logic [1:0]       hwy_q, hwy_d;
    logic [1:0]       cntry_q, cntry_d;
    logic [2:0]       phase_q;
    logic             cg_cap;

    // Country green hits its ceiling only when the cap is compiled in.
    assign cg_cap = MAX_EN && (timer_q == MAX_LAST);

    // Two-flop synchroniser for the asynchronous car sensor.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            x_meta_q <= 1'b0;
            x_s_q    <= 1'b0;
        end else begin
            x_meta_q <= x;
            x_s_q    <= x_meta_q;
        end
    end

    // Next-state, dwell timer and lamp decode from the pre-edge timer value.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hwy_d   = LAMP_RED;
        cntry_d = LAMP_RED;

        case (state_q)
            HG:      if (x_s_q && (timer_q >= MIN_LAST)) state_d = HY;
            HY:      if (timer_q == YEL_LAST)            state_d = AR1;
            AR1:     if (timer_q == AR_LAST)             state_d = CG;
            CG:      if ((!x_s_q && (timer_q >= MIN_LAST)) || cg_cap) state_d = CY;
            CY:      if (timer_q == YEL_LAST)            state_d = AR2;
            AR2:     if (timer_q == AR_LAST)             state_d = HG;
            default: state_d = HG;
        endcase

        // Restart on state entry; otherwise count and hold at all-ones.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end

        // Lamps follow the state being entered so they move with the state register.
        case (state_d)
            HG:      hwy_d   = LAMP_GRN;
            HY:      hwy_d   = LAMP_YEL;
            CG:      cntry_d = LAMP_GRN;
            CY:      cntry_d = LAMP_YEL;
            default: begin
                hwy_d   = LAMP_RED;
                cntry_d = LAMP_RED;
            end
        endcase
    end

    // State, timer and registered lamp/phase outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= HG;
            timer_q <= '0;
            hwy_q   <= LAMP_GRN;
            cntry_q <= LAMP_RED;
            phase_q <= 3'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hwy_q   <= hwy_d;
            cntry_q <= cntry_d;
            phase_q <= state_d;
        end
    end

    assign hwy   = hwy_q;
    assign cntry = cntry_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_hwy_cntry_light_ctrl.sv
module tb_hwy_cntry_light_ctrl;

    logic       clock = 1'b0;
    logic       clear_n = 1'b1;
    logic       x = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] phase;

    int checks = 0;
    int passed = 0;

    // Expected outputs after edges 1..20 with x=1 from release and x dropped after edge 12.
    int exp_ph [20] = '{0,0,0,1,1,1,2,2,3,3,3,3,3,3,4,4,4,5,5,0};
    int exp_hw [20] = '{2,2,2,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,2};
    int exp_cn [20] = '{0,0,0,0,0,0,0,0,2,2,2,2,2,2,1,1,1,0,0,0};

    hwy_cntry_light_ctrl dut (
        .clock   (clock),
        .clear_n (clear_n),
        .x       (x),
        .hwy     (hwy),
        .cntry   (cntry),
        .phase   (phase)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset pulse released well away from the next rising edge; that edge is edge 1.
    task automatic do_reset();
        tick();
        clear_n = 1'b0;
        #2;
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        x = 1'($urandom_range(0, 1));
        clear_n = 1'b0;
        #1;
        checks++; if (hwy !== 2'd2) $display("FAIL reset_hwy: got %0d expected 2", hwy); else passed++;
        checks++; if (cntry !== 2'd0) $display("FAIL reset_cntry: got %0d expected 0", cntry); else passed++;
        checks++; if (phase !== 3'd0) $display("FAIL reset_phase: got %0d expected 0", phase); else passed++;
        clear_n = 1'b1;
    endtask

    task automatic test_default_seq();
        x = 1'b1;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 12) x = 1'b0;
            checks++; if (phase !== 3'(exp_ph[e-1])) $display("FAIL seq_phase e%0d: got %0d expected %0d", e, phase, exp_ph[e-1]); else passed++;
            checks++; if (hwy !== 2'(exp_hw[e-1])) $display("FAIL seq_hwy e%0d: got %0d expected %0d", e, hwy, exp_hw[e-1]); else passed++;
            checks++; if (cntry !== 2'(exp_cn[e-1])) $display("FAIL seq_cntry e%0d: got %0d expected %0d", e, cntry, exp_cn[e-1]); else passed++;
        end
    endtask

`ifdef MAX_GREEN_EN
    task automatic test_max_green();
        x = 1'b1;
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            tick();
            case (e)
                8:  begin checks++; if (phase !== 3'd2) $display("FAIL max_ar1 e8: got %0d expected 2", phase); else passed++; end
                9:  begin checks++; if (phase !== 3'd3) $display("FAIL max_cg e9: got %0d expected 3", phase); else passed++; end
                16: begin checks++; if (cntry !== 2'd2) $display("FAIL max_cg e16: got %0d expected 2", cntry); else passed++; end
                17: begin checks++; if (cntry !== 2'd1) $display("FAIL max_cy e17: got %0d expected 1", cntry); else passed++; end
                21: begin checks++; if (hwy !== 2'd0) $display("FAIL max_ar2 e21: got %0d expected 0", hwy); else passed++; end
                22: begin checks++; if (hwy !== 2'd2) $display("FAIL max_hg e22: got %0d expected 2", hwy); else passed++; end
                25: begin checks++; if (hwy !== 2'd2) $display("FAIL max_hgmin e25: got %0d expected 2", hwy); else passed++; end
                26: begin checks++; if (hwy !== 2'd1) $display("FAIL max_hy e26: got %0d expected 1", hwy); else passed++; end
                default: ;
            endcase
        end
    endtask
`else
    task automatic test_cg_hold();
        x = 1'b1;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 9 || e == 17 || e == 30) begin
                checks++; if (phase !== 3'd3) $display("FAIL cg_hold e%0d: got %0d expected 3", e, phase); else passed++;
                checks++; if (cntry !== 2'd2) $display("FAIL cg_hold_lamp e%0d: got %0d expected 2", e, cntry); else passed++;
            end
        end
    endtask
`endif

    // A glitch that no rising edge samples must leave the highway green.
    task automatic test_glitch();
        x = 1'b0;
        do_reset();
        for (int e = 1; e <= 10; e++) tick();
        #2; x = 1'b1;
        #4; x = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++; if (phase !== 3'd0) $display("FAIL glitch_phase c%0d: got %0d expected 0", e, phase); else passed++;
        end
    endtask

    // A single sampled pulse is served; its drop does not abort the handover.
    task automatic test_sampled_pulse();
        x = 1'b0;
        do_reset();
        for (int e = 1; e <= 10; e++) tick();
        x = 1'b1;
        tick();
        x = 1'b0;
        for (int e = 12; e <= 22; e++) begin
            tick();
            case (e)
                12: begin checks++; if (phase !== 3'd0) $display("FAIL pulse_hg e12: got %0d expected 0", phase); else passed++; end
                13: begin checks++; if (hwy !== 2'd1) $display("FAIL pulse_hy e13: got %0d expected 1", hwy); else passed++; end
                18: begin checks++; if (phase !== 3'd3) $display("FAIL pulse_cg e18: got %0d expected 3", phase); else passed++; end
                21: begin checks++; if (phase !== 3'd3) $display("FAIL pulse_cgmin e21: got %0d expected 3", phase); else passed++; end
                22: begin checks++; if (phase !== 3'd4) $display("FAIL pulse_cy e22: got %0d expected 4", phase); else passed++; end
                default: ;
            endcase
        end
    endtask

    task automatic test_clear_mid();
        x = 1'b1;
        do_reset();
        for (int e = 1; e <= 5; e++) tick();
        clear_n = 1'b0;
        #1;
        checks++; if (hwy !== 2'd2) $display("FAIL clr_yel_hwy: got %0d expected 2", hwy); else passed++;
        #1; clear_n = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        checks++; if (phase !== 3'd3) $display("FAIL clr_pre_cg: got %0d expected 3", phase); else passed++;
        clear_n = 1'b0;
        #1;
        checks++; if (cntry !== 2'd0) $display("FAIL clr_cntry: got %0d expected 0", cntry); else passed++;
        checks++; if (hwy !== 2'd2) $display("FAIL clr_hwy: got %0d expected 2", hwy); else passed++;
        checks++; if (phase !== 3'd0) $display("FAIL clr_phase: got %0d expected 0", phase); else passed++;
        #1; clear_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e < 4) begin
                checks++; if (phase !== 3'd0) $display("FAIL clr_restart e%0d: got %0d expected 0", e, phase); else passed++;
            end else begin
                checks++; if (hwy !== 2'd1) $display("FAIL clr_hy e4: got %0d expected 1", hwy); else passed++;
            end
        end
    endtask

    // After a long hold the timer must still satisfy the minimum: HY three edges after x rises.
    task automatic test_saturation();
        x = 1'b0;
        do_reset();
        for (int e = 1; e <= 46; e++) tick();
        x = 1'b1;
        tick();
        tick();
        checks++; if (phase !== 3'd0) $display("FAIL sat_hold: got %0d expected 0", phase); else passed++;
        tick();
        checks++; if (phase !== 3'd1) $display("FAIL sat_hy: got %0d expected 1", phase); else passed++;
    endtask

    task automatic test_random();
        x = 1'b0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            tick();
            x = 1'($urandom_range(0, 1));
            checks++;
            if (hwy !== 2'd0 && cntry !== 2'd0) $display("FAIL rnd_both_nonred c%0d: hwy %0d cntry %0d expected one red", c, hwy, cntry);
            else passed++;
            checks++;
            if (phase > 3'd5) $display("FAIL rnd_phase c%0d: got %0d expected 0..5", c, phase);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_default_seq();
`ifdef MAX_GREEN_EN
        test_max_green();
`else
        test_cg_hold();
`endif
        test_glitch();
        test_sampled_pulse();
        test_clear_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
